// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fifo_share_arb slice: default parameters, the
// requester-id width derivation and {id, payload} entry pack/unpack helpers.
package fifo_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int DW_DEF    = 3;
  localparam int AW_DEF    = 4;
  localparam int QUOTA_DEF = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int idw_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Build a {id, payload} entry, payload in the low dw bits.
  function automatic logic [31:0] entry_pack(input logic [31:0] id,
                                             input logic [31:0] data,
                                             input int          dw);
    return (id << dw) | (data & ((32'd1 << dw) - 32'd1));
  endfunction

  // Requester id field of an entry.
  function automatic logic [31:0] entry_id(input logic [31:0] entry,
                                           input int          dw);
    return entry >> dw;
  endfunction

  // Payload field of an entry.
  function automatic logic [31:0] entry_data(input logic [31:0] entry,
                                             input int          dw);
    return entry & ((32'd1 << dw) - 32'd1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority one-hot picker: returns the first asserted elig bit
// found by scanning rr_ptr, rr_ptr+1, ... with wrap at N-1. The wrap is an
// explicit compare so non-power-of-two N never aliases onto a bad index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id,
  output logic          grant_any
);

  logic [IW-1:0] idx;

  // Scan all N positions from rr_ptr and latch onto the first eligible one.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = rr_ptr;
    for (int k = 0; k < N; k++) begin
      if (!grant_any && elig[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        grant_any  = 1'b1;
      end else begin
        grant_any  = grant_any;
      end
      if (idx == IW'(N - 1)) begin
        idx = '0;
      end else begin
        idx = idx + IW'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_share_arb.sv
// fifo_share_arb: round-robin sharing of one external synchronous FIFO among
// NREQ requesters. At most one push per cycle, each entry tagged with the
// requester id; the FIFO head is presented as a valid/ready stream.
// Optional per-requester occupancy quota: define FIFO_ARB_QUOTA_EN.
// Grant and pop paths are combinational so a requester sees ready in the
// same cycle it raises valid. While rst_n is low every strobe is held off.
module fifo_share_arb
  import fifo_arb_pkg::*;
#(
  parameter int  NREQ  = NREQ_DEF,
  parameter int  DW    = DW_DEF,
  parameter int  AW    = AW_DEF,
  parameter int  QUOTA = QUOTA_DEF,
  localparam int IDW   = idw_of(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_vld,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_rdy,
  output logic                out_vld,
  output logic [DW-1:0]       out_data,
  output logic [IDW-1:0]      out_id,
  input  logic                out_rdy,
  output logic                fifo_push,
  output logic [IDW+DW-1:0]   fifo_din,
  output logic                fifo_pop,
  input  logic [IDW+DW-1:0]   fifo_dout,
  input  logic                fifo_empty,
  input  logic                fifo_full,
  output logic                busy
);

  localparam int EW = IDW + DW;

  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] below_quota;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;
  logic [DW-1:0]   grant_data;

`ifdef FIFO_ARB_QUOTA_EN
  localparam int CW = $clog2(QUOTA + 1);

  logic [CW-1:0] cnt [NREQ];

  // A requester already holding QUOTA entries drops out of arbitration.
  always_comb begin
    below_quota = '0;
    for (int i = 0; i < NREQ; i++) begin
      below_quota[i] = (cnt[i] < CW'(QUOTA));
    end
  end

  // Track how many queued entries each requester owns (push +1, pop -1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case ({grant[i], fifo_pop && (out_id == IDW'(i))})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= (cnt[i] != '0) ? cnt[i] - CW'(1) : cnt[i];
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end
`else
  assign below_quota = '1;
`endif

  // Eligible: requesting, room in the FIFO (no pop bypass), within quota,
  // and not in reset.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_vld[i] & ~fifo_full & below_quota[i] & rst_n;
    end
  end

  rr_pick #(
    .N  (NREQ),
    .IW (IDW)
  ) u_pick (
    .elig      (elig),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  // Select the winning requester's payload.
  always_comb begin
    grant_data = req_data[int'(grant_id) * DW +: DW];
  end

  // Priority moves to the index after the winner; holds when nothing pushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end else begin
      rr_ptr <= rr_ptr;
    end
  end

  assign req_rdy   = grant;
  assign fifo_push = grant_any;
  assign fifo_din  = EW'(entry_pack(32'(grant_id), 32'(grant_data), DW));

  assign out_vld   = ~fifo_empty & rst_n;
  assign out_id    = IDW'(entry_id(32'(fifo_dout), DW));
  assign out_data  = DW'(entry_data(32'(fifo_dout), DW));
  assign fifo_pop  = out_vld & out_rdy;

  assign busy      = rst_n & (~fifo_empty | (|req_vld));

endmodule

// File: tb/tb_fifo_share_arb.sv
// Bench for fifo_share_arb: a behavioural FIFO sits on the fifo_* pins, a
// reference model predicts grants, and a scoreboard queue holds expected
// entries until they pop out of the head.
module tb_fifo_share_arb;

  localparam int NREQ  = 4;
  localparam int DW    = 3;
  localparam int AW    = 4;
  localparam int IDW   = 2;
  localparam int QUOTA = 4;
  localparam int DEPTH = 16;
  localparam int EW    = IDW + DW;
`ifdef FIFO_ARB_QUOTA_EN
  localparam bit QON = 1'b1;
`else
  localparam bit QON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_vld = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_rdy;
  logic               out_vld;
  logic [DW-1:0]      out_data;
  logic [IDW-1:0]     out_id;
  logic               out_rdy = 1'b0;
  logic               fifo_push;
  logic [EW-1:0]      fifo_din;
  logic               fifo_pop;
  logic [EW-1:0]      fifo_dout;
  logic               fifo_empty;
  logic               fifo_full;
  logic               busy;

  // Second instance with three requesters for the wrap case.
  logic [2:0] r3_vld = '0;
  logic [8:0] r3_data = '0;
  logic [2:0] r3_rdy;
  logic       r3_out_vld;
  logic [2:0] r3_out_data;
  logic [1:0] r3_out_id;
  logic       r3_push;
  logic [4:0] r3_din;
  logic       r3_pop;
  logic       r3_busy;

  int compared = 0;
  int mismatched = 0;

  fifo_share_arb #(.NREQ(NREQ), .DW(DW), .AW(AW), .QUOTA(QUOTA)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_data(req_data),
    .req_rdy(req_rdy), .out_vld(out_vld), .out_data(out_data), .out_id(out_id),
    .out_rdy(out_rdy), .fifo_push(fifo_push), .fifo_din(fifo_din),
    .fifo_pop(fifo_pop), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .busy(busy)
  );

  fifo_share_arb #(.NREQ(3), .DW(3), .AW(4), .QUOTA(4)) u3 (
    .clk(clk), .rst_n(rst_n), .req_vld(r3_vld), .req_data(r3_data),
    .req_rdy(r3_rdy), .out_vld(r3_out_vld), .out_data(r3_out_data),
    .out_id(r3_out_id), .out_rdy(1'b0), .fifo_push(r3_push), .fifo_din(r3_din),
    .fifo_pop(r3_pop), .fifo_dout(5'b00000), .fifo_empty(1'b1),
    .fifo_full(1'b0), .busy(r3_busy)
  );

  // Behavioural FIFO
  logic [EW-1:0] mem [DEPTH];
  int wp = 0, rp = 0, fcount = 0;
  assign fifo_empty = (fcount == 0);
  assign fifo_full  = (fcount == DEPTH);
  assign fifo_dout  = mem[rp];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= 0; rp <= 0; fcount <= 0;
    end else begin
      if (fifo_push && !fifo_full) begin
        mem[wp] <= fifo_din;
        wp <= (wp + 1) % DEPTH;
      end
      if (fifo_pop && !fifo_empty) rp <= (rp + 1) % DEPTH;
      fcount <= fcount + ((fifo_push && !fifo_full) ? 1 : 0)
                       - ((fifo_pop && !fifo_empty) ? 1 : 0);
    end
  end

  // Reference model and scoreboard
  logic [EW-1:0] sb[$];
  int m_ptr = 0;
  int m_cnt[NREQ] = '{0, 0, 0, 0};

  function automatic int model_pick(input logic [NREQ-1:0] vld, input bit full);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      bit ok;
      idx = (m_ptr + k) % NREQ;
      ok = vld[idx] && !full;
      if (QON && m_cnt[idx] >= QUOTA) ok = 1'b0;
      if (ok) return idx;
    end
    return -1;
  endfunction

  always @(negedge rst_n) begin
    sb.delete();
    m_ptr = 0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
  end

  always @(negedge clk) begin
    int sz, g;
    logic [NREQ-1:0] exp_rdy;
    logic [EW-1:0] exp_din, head;
    bit exp_pop, exp_busy;
    if (!rst_n) begin
      compared++;
      if (req_rdy !== '0 || fifo_push !== 1'b0 || fifo_pop !== 1'b0 ||
          out_vld !== 1'b0 || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_outputs: rdy=%b push=%b pop=%b vld=%b busy=%b, required all 0",
                 req_rdy, fifo_push, fifo_pop, out_vld, busy);
      end
    end else begin
      sz = sb.size();
      g = model_pick(req_vld, sz == DEPTH);
      exp_rdy = (g < 0) ? '0 : (4'b0001 << g);
      exp_busy = (sz != 0) || (|req_vld);
      exp_pop = (sz != 0) && out_rdy;
      compared++;
      if (out_vld !== (sz != 0)) begin
        mismatched++;
        $display("FAIL out_vld: got %b required %b", out_vld, (sz != 0));
      end
      compared++;
      if (fifo_pop !== exp_pop) begin
        mismatched++;
        $display("FAIL fifo_pop: got %b required %b", fifo_pop, exp_pop);
      end
      compared++;
      if (req_rdy !== exp_rdy) begin
        mismatched++;
        $display("FAIL req_rdy: got %b required %b", req_rdy, exp_rdy);
      end
      compared++;
      if (busy !== exp_busy) begin
        mismatched++;
        $display("FAIL busy: got %b required %b", busy, exp_busy);
      end
      if (exp_pop) begin
        head = sb.pop_front();
        compared++;
        if ({out_id, out_data} !== head) begin
          mismatched++;
          $display("FAIL head_entry: got %h required %h", {out_id, out_data}, head);
        end
        m_cnt[head[EW-1:DW]]--;
      end
      if (g >= 0) begin
        exp_din = {2'(g), req_data[g*DW +: DW]};
        compared++;
        if (fifo_din !== exp_din) begin
          mismatched++;
          $display("FAIL fifo_din: got %h required %h", fifo_din, exp_din);
        end
        sb.push_back(exp_din);
        m_cnt[g]++;
        m_ptr = (g + 1) % NREQ;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NREQ-1:0] vld, input logic rdy);
    req_vld  = vld;
    out_rdy  = rdy;
    req_data = 12'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    drive(4'b0000, 1'b1);
    while (fcount != 0 && n < 40) begin
      tick();
      n++;
    end
    compared++;
    if (fcount != 0) begin
      mismatched++;
      $display("FAIL drain_timeout: %0d entries left, required 0", fcount);
    end
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(4'b1111, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if (req_rdy !== 4'b0000 || fifo_push !== 1'b0) begin
      mismatched++;
      $display("FAIL grant_in_reset: rdy=%b push=%b required 0000/0", req_rdy, fifo_push);
    end
    tick();
    drive(4'b0000, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if ({req_rdy, fifo_push, fifo_pop, out_vld, busy} !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_idle: got %b required 00000000",
               {req_rdy, fifo_push, fifo_pop, out_vld, busy});
    end
    tick();
  endtask

  task automatic test_rr_order();
    for (int i = 0; i < 4; i++) begin
      drive(4'b1111, 1'b0);
      @(negedge clk);
      compared++;
      if (req_rdy !== 4'(1 << i) || fifo_din[EW-1:DW] !== 2'(i)) begin
        mismatched++;
        $display("FAIL rr_order[%0d]: rdy=%b tag=%0d required %b/%0d",
                 i, req_rdy, fifo_din[EW-1:DW], 4'(1 << i), i);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_full();
    logic [3:0] exp;
    for (int i = 0; i < DEPTH; i++) begin
      drive(4'b1111, 1'b0);
      tick();
    end
    drive(4'b0010, 1'b1);
    @(negedge clk);
    compared++;
    if (fifo_full !== 1'b1 || req_rdy !== 4'b0000 || fifo_pop !== 1'b1) begin
      mismatched++;
      $display("FAIL full_no_bypass: full=%b rdy=%b pop=%b required 1/0000/1",
               fifo_full, req_rdy, fifo_pop);
    end
    tick();
    drive(4'b0010, 1'b1);
    @(negedge clk);
    exp = QON ? 4'b0000 : 4'b0010;
    compared++;
    if (req_rdy !== exp) begin
      mismatched++;
      $display("FAIL after_full: rdy=%b required %b", req_rdy, exp);
    end
    tick();
    drain();
  endtask

  task automatic test_quota();
    bit exp;
    for (int i = 0; i < 5; i++) begin
      drive(4'b0100, 1'b0);
      @(negedge clk);
      exp = !(QON && i >= QUOTA);
      compared++;
      if (req_rdy[2] !== exp) begin
        mismatched++;
        $display("FAIL quota_push[%0d]: rdy2=%b required %b", i, req_rdy[2], exp);
      end
      tick();
    end
    drive(4'b0100, 1'b1);
    @(negedge clk);
    compared++;
    if (fifo_pop !== 1'b1 || out_id !== 2'd2 || req_rdy[2] !== !QON) begin
      mismatched++;
      $display("FAIL quota_pop: pop=%b id=%0d rdy2=%b required 1/2/%b",
               fifo_pop, out_id, req_rdy[2], !QON);
    end
    tick();
    drive(4'b0100, 1'b0);
    @(negedge clk);
    compared++;
    if (req_rdy !== 4'b0100) begin
      mismatched++;
      $display("FAIL quota_resume: rdy=%b required 0100", req_rdy);
    end
    tick();
    drain();
  endtask

  task automatic test_same_cycle();
    logic [3:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive(4'b1000, 1'b0);
      tick();
    end
    drive(4'b1000, 1'b1);
    @(negedge clk);
    exp = QON ? 4'b0000 : 4'b1000;
    compared++;
    if (fifo_pop !== 1'b1 || out_id !== 2'd3 || req_rdy !== exp) begin
      mismatched++;
      $display("FAIL pop_at_quota: pop=%b id=%0d rdy=%b required 1/3/%b",
               fifo_pop, out_id, req_rdy, exp);
    end
    tick();
    drive(4'b1000, 1'b0);
    @(negedge clk);
    compared++;
    if (req_rdy !== 4'b1000) begin
      mismatched++;
      $display("FAIL grant_after_pop: rdy=%b required 1000", req_rdy);
    end
    tick();
    drain();
  endtask

  task automatic test_wrap3();
    logic [2:0] vld_seq [4] = '{3'b010, 3'b101, 3'b101, 3'b111};
    logic [2:0] exp_seq [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
    for (int i = 0; i < 4; i++) begin
      r3_vld  = vld_seq[i];
      r3_data = 9'($urandom);
      @(negedge clk);
      compared++;
      if (r3_rdy !== exp_seq[i] || r3_push !== 1'b1 || r3_pop !== 1'b0 ||
          r3_out_vld !== 1'b0 || r3_busy !== 1'b1) begin
        mismatched++;
        $display("FAIL wrap3[%0d]: rdy=%b push=%b pop=%b vld=%b busy=%b required %b/1/0/0/1",
                 i, r3_rdy, r3_push, r3_pop, r3_out_vld, r3_busy, exp_seq[i]);
      end
      tick();
    end
    r3_vld = 3'b000;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0111, 1'b0);
      tick();
    end
    drive(4'b0000, 1'b0);
    #2;
    rst_n = 1'b0;
    drive(4'b1111, 1'b1);
    #1;
    compared++;
    if ({req_rdy, fifo_push, fifo_pop, out_vld, busy} !== 8'h00) begin
      mismatched++;
      $display("FAIL mid_reset: got %b required 00000000",
               {req_rdy, fifo_push, fifo_pop, out_vld, busy});
    end
    tick();
    tick();
    drive(4'b1111, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (req_rdy !== 4'b0001) begin
      mismatched++;
      $display("FAIL ptr_after_reset: rdy=%b required 0001", req_rdy);
    end
    tick();
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rr_order();
    test_full();
    test_quota();
    test_same_cycle();
    test_wrap3();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
